// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-through, no-write-allocate data cache with
// one 32-bit word per line. Valid bits, tags and data are held in flops.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   dcache_addr/re/we/din/dout  CPU side (byte address, read strobe, byte
//                       write strobes, write data, registered read data)
//   stall               high whenever the controller is not idle
//   mem_req_*           backing-memory request channel (valid/ready handshake)
//   mem_resp_valid/data backing-memory read response (one cycle per response)
//   hit_count, miss_count  wrapping performance counters
module dmem_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_strb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 30 - IDX;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  // Replace the strobed bytes of old_word with the matching bytes of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [LINES-1:0] valid_r;
  logic [TAGW-1:0]  tag_r  [LINES];
  logic [31:0]      data_r [LINES];
  logic [31:0]      req_addr_r;
  logic [31:0]      req_data_r;
  logic [3:0]       req_strb_r;

  logic [IDX-1:0]   idx_s;
  logic [TAGW-1:0]  tag_s;
  logic [IDX-1:0]   fill_idx_s;
  logic [TAGW-1:0]  fill_tag_s;
  logic             hit_s;
  logic             is_write_s;
  logic             accept_s;
  logic             write_hit_s;
  logic             fill_s;
  logic             unused_s;

  assign idx_s       = dcache_addr[IDX+1:2];
  assign tag_s       = dcache_addr[31:IDX+2];
  assign fill_idx_s  = req_addr_r[IDX+1:2];
  assign fill_tag_s  = req_addr_r[31:IDX+2];
  assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign is_write_s  = (dcache_we != 4'b0000);
  assign accept_s    = (state_r == IDLE) && (dcache_re || is_write_s);
  assign write_hit_s = accept_s && is_write_s && hit_s;
  assign fill_s      = (state_r == RD_WAIT) && mem_resp_valid;
  // Byte-offset bits of the CPU address play no part in a word cache.
  assign unused_s    = ^dcache_addr[1:0];

  // Request outputs are pure decodes of registered state, so they cannot
  // change while a request waits for ready.
  assign stall         = (state_r != IDLE);
  assign mem_req_valid = (state_r == RD_REQ) || (state_r == WR_REQ);
  assign mem_req_rw    = (state_r == WR_REQ);
  assign mem_req_addr  = req_addr_r;
  assign mem_req_data  = req_data_r;
  assign mem_req_strb  = req_strb_r;

  // Next-state decode of the miss/write-through controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_write_s) begin
          state_nxt_s = WR_REQ;
        end else if (accept_s && !hit_s) begin
          state_nxt_s = RD_REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_REQ:  state_nxt_s = mem_req_ready  ? RD_WAIT : RD_REQ;
      RD_WAIT: state_nxt_s = mem_resp_valid ? IDLE    : RD_WAIT;
      WR_REQ:  state_nxt_s = mem_req_ready  ? IDLE    : WR_REQ;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Controller state, valid bits, read data, latched request and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      dcache_dout <= 32'd0;
      req_addr_r  <= 32'd0;
      req_data_r  <= 32'd0;
      req_strb_r  <= 4'b0000;
      hit_count   <= 32'd0;
      miss_count  <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        if (hit_s) begin
          hit_count <= hit_count + 32'd1;
        end else begin
          miss_count <= miss_count + 32'd1;
        end
        if (is_write_s) begin
          // Every write goes through to memory; dout is left alone.
          req_addr_r <= {dcache_addr[31:2], 2'b00};
          req_data_r <= dcache_din;
          req_strb_r <= dcache_we;
        end else if (hit_s) begin
          dcache_dout <= data_r[idx_s];
        end else begin
          req_addr_r <= {dcache_addr[31:2], 2'b00};
          req_strb_r <= 4'b0000;
        end
      end
      if (fill_s) begin
        valid_r[fill_idx_s] <= 1'b1;
        dcache_dout         <= mem_resp_data;
      end
    end
  end

  // Tag and data arrays; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && write_hit_s) begin
      data_r[idx_s] <= merge_bytes(data_r[idx_s], dcache_din, dcache_we);
    end else if (!rst && fill_s) begin
      data_r[fill_idx_s] <= mem_resp_data;
      tag_r[fill_idx_s]  <= fill_tag_s;
    end
  end

endmodule

// File: tb/tb_dmem_cache.sv
// Self-checking bench for dmem_cache: directed scenarios followed by random
// reads/writes, all compared against a word-addressed reference model of the
// cache contents and the backing memory.
module tb_dmem_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_strb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dmem_cache #(.LINES(64)) dut (
    .clk(clk), .rst(rst),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_strb(mem_req_strb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each line remembers the full word address it holds.
  bit          m_valid [64];
  logic [31:0] m_waddr [64];
  logic [31:0] m_data  [64];
  logic [31:0] exp_dout, exp_hit, exp_miss;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic mem_get(input logic [31:0] wa, output logic [31:0] v);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    v = mem[wa];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    exp_dout = 32'd0;
    exp_hit  = 32'd0;
    exp_miss = 32'd0;
  endtask

  // Called and returning at a falling edge.
  task automatic do_read(input logic [31:0] a, input int rdly, input int vdly);
    logic [31:0] wa, rd;
    int i, stalls;
    bit hit;
    wa = {a[31:2], 2'b00};
    i = int'((wa >> 2) % 64);
    hit = m_valid[i] && (m_waddr[i] == wa);
    stalls = 0;
    dcache_addr = a; dcache_re = 1'b1; dcache_we = 4'b0000;
    @(negedge clk);
    dcache_re = 1'b0;
    if (hit) begin
      exp_hit = exp_hit + 32'd1;
      exp_dout = m_data[i];
      chk("rd_hit_stall", {31'd0, stall}, 32'd0);
      chk("rd_hit_dout", dcache_dout, exp_dout);
    end else begin
      exp_miss = exp_miss + 32'd1;
      chk("rd_miss_dout_hold", dcache_dout, exp_dout);
      for (int k = 0; k <= rdly; k++) begin
        stalls += int'(stall);
        chk("rd_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("rd_req_rw", {31'd0, mem_req_rw}, 32'd0);
        chk("rd_req_addr", mem_req_addr, wa);
        chk("rd_req_strb", {28'd0, mem_req_strb}, 32'd0);
        mem_req_ready = (k == rdly);
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      mem_get(wa, rd);
      for (int k = 0; k <= vdly; k++) begin
        stalls += int'(stall);
        chk("rd_wait_novalid", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_valid = (k == vdly);
        mem_resp_data  = (k == vdly) ? rd : $urandom;
        @(negedge clk);
      end
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      m_valid[i] = 1'b1; m_waddr[i] = wa; m_data[i] = rd; exp_dout = rd;
      chk("rd_fill_stall_low", {31'd0, stall}, 32'd0);
      chk("rd_miss_stall_cycles", 32'(stalls), 32'(rdly + vdly + 2));
      chk("rd_fill_dout", dcache_dout, exp_dout);
    end
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                          input int rdly, input bit also_re);
    logic [31:0] wa, mv;
    int i;
    bit hit;
    wa = {a[31:2], 2'b00};
    i = int'((wa >> 2) % 64);
    hit = m_valid[i] && (m_waddr[i] == wa);
    dcache_addr = a; dcache_we = we; dcache_din = din; dcache_re = also_re;
    @(negedge clk);
    dcache_we = 4'b0000; dcache_re = 1'b0; dcache_din = $urandom;
    if (hit) begin
      exp_hit = exp_hit + 32'd1;
      m_data[i] = merge(m_data[i], din, we);
    end else begin
      exp_miss = exp_miss + 32'd1;
    end
    chk("wr_dout_hold", dcache_dout, exp_dout);
    for (int k = 0; k <= rdly; k++) begin
      chk("wr_stall", {31'd0, stall}, 32'd1);
      chk("wr_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("wr_req_rw", {31'd0, mem_req_rw}, 32'd1);
      chk("wr_req_addr", mem_req_addr, wa);
      chk("wr_req_data", mem_req_data, din);
      chk("wr_req_strb", {28'd0, mem_req_strb}, {28'd0, we});
      mem_resp_valid = 1'($urandom % 2);   // spurious, must be ignored
      mem_resp_data  = $urandom;
      mem_req_ready  = (k == rdly);
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_get(wa, mv);
    mem[wa] = merge(mv, din, we);
    chk("wr_done_stall", {31'd0, stall}, 32'd0);
    chk("wr_done_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("wr_dout_after", dcache_dout, exp_dout);
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
  endtask

  initial begin
    logic [31:0] ra, rdin;
    logic [3:0]  rwe;
    rst = 1'b1; dcache_addr = 32'd0; dcache_re = 1'b0; dcache_we = 4'b0000;
    dcache_din = 32'd0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_dout", dcache_dout, 32'd0);
    chk("rst_hit", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    rst = 1'b0;

    // Cold read miss, then hit on the filled line.
    mem[32'h100] = 32'hDEADBEEF;
    do_read(32'h100, 0, 1);
    chk("cold_dout", dcache_dout, 32'hDEADBEEF);
    do_read(32'h100, 0, 0);
    chk("warm_dout", dcache_dout, 32'hDEADBEEF);

    // Byte write hit with re also set (write wins), then read back merged word.
    do_write(32'h100, 4'b0010, 32'h0000AB00, 0, 1'b1);
    do_read(32'h101, 0, 0);
    chk("merged_dout", dcache_dout, 32'hDEADABEF);

    // Conflict on index 0: 0x200 evicts 0x100.
    do_read(32'h200, 1, 2);
    do_read(32'h100, 0, 0);
    chk("refill_dout", dcache_dout, 32'hDEADABEF);

    // Write miss under backpressure; no allocation, so the read misses.
    do_write(32'h104, 4'b1111, 32'h13572468, 5, 1'b0);
    do_read(32'h104, 2, 0);
    chk("wr_through_dout", dcache_dout, 32'h13572468);

    // Reset while waiting for a response; the late response is ignored.
    dcache_addr = 32'h300; dcache_re = 1'b1;
    @(negedge clk);
    dcache_re = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; model_reset();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    chk("rstmid_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rstmid_dout", dcache_dout, 32'd0);
    chk("rstmid_miss", miss_count, 32'd0);
    do_read(32'h300, 0, 0);
    chk("rstmid_refetch_miss", miss_count, 32'd1);
    // Reset with immediate request on the first cycle afterwards.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; model_reset();
    do_read(32'h100, 0, 0);

    // Random traffic over a few indices and tags so hits and conflicts mix.
    for (int n = 0; n < 300; n++) begin
      ra = ((32'($urandom % 4)) << 8) | ((32'($urandom % 8)) << 2) | 32'($urandom % 4);
      if ($urandom % 3 == 0) begin
        rwe  = 4'($urandom_range(1, 15));
        rdin = $urandom;
        do_write(ra, rwe, rdin, int'($urandom % 4), 1'($urandom % 2));
      end else begin
        do_read(ra, int'($urandom % 4), int'($urandom % 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
